// File: rtl/pa_fpu_pkg.sv
// pa_fpu_pkg: shared types and constants for the FPU write-back controller.
// Holds the FDSU tracking state encoding, the FDSU unit-select code and the
// bus widths used by the controller, its arbiter and its interface.
package pa_fpu_pkg;

    localparam int DATA_W = 32;
    localparam int FLAG_W = 5;
    localparam int REG_W  = 5;
    localparam int SEL_W  = 3;

    localparam logic [SEL_W-1:0] EU_FDSU = 3'b100;

    // IDLE: no divide/sqrt op in flight; RUN: op outstanding in the FDSU;
    // WB: FDSU result buffered and waiting for the register-file port.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } fdsu_state_e;

    // An EX1 op goes to the iterative FDSU unless the unit resolved it early,
    // in which case its result flows down the ordinary EX2 path.
    function automatic logic is_fdsu_issue(input logic             inst_vld,
                                           input logic [SEL_W-1:0] eu_sel,
                                           input logic             special);
        return inst_vld && (eu_sel == EU_FDSU) && !special;
    endfunction

endpackage

// File: rtl/pa_fpu_wb_ctrl_if.sv
// pa_fpu_wb_ctrl_if: register-file write-back request/grant bus.
// The controller drives the request side (master); the register file answers
// with the grant (slave).
interface pa_fpu_wb_ctrl_if;
    import pa_fpu_pkg::*;

    logic              fpu_rf_wb_vld;
    logic [DATA_W-1:0] fpu_rf_wb_data;
    logic [FLAG_W-1:0] fpu_rf_wb_fflags;
    logic [REG_W-1:0]  fpu_rf_wb_dst;
    logic              rf_fpu_wb_grant;

    modport master (
        output fpu_rf_wb_vld,
        output fpu_rf_wb_data,
        output fpu_rf_wb_fflags,
        output fpu_rf_wb_dst,
        input  rf_fpu_wb_grant
    );

    modport slave (
        input  fpu_rf_wb_vld,
        input  fpu_rf_wb_data,
        input  fpu_rf_wb_fflags,
        input  fpu_rf_wb_dst,
        output rf_fpu_wb_grant
    );

endinterface

// File: rtl/pa_fpu_wb_arb.sv
// pa_fpu_wb_arb: two-source fixed-priority write-back selector.
// Source 0 is the buffered FDSU result, held in local registers from capture
// until it is granted; source 1 is the live EX2 result. The buffered FDSU
// result always wins. Outputs are forced to zero while no request is shown.
module pa_fpu_wb_arb
    import pa_fpu_pkg::*;
(
    input  logic              clk,
    input  logic              dst_load,
    input  logic [REG_W-1:0]  dst_in,
    input  logic              res_load,
    input  logic [DATA_W-1:0] res_data,
    input  logic [FLAG_W-1:0] res_fflags,
    input  logic              buf_vld,
    input  logic              ex2_vld,
    input  logic              ex2_wb,
    input  logic [DATA_W-1:0] ex2_data,
    input  logic [FLAG_W-1:0] ex2_fflags,
    input  logic [REG_W-1:0]  ex2_dst,
    input  logic              grant,
    output logic              wb_vld,
    output logic [DATA_W-1:0] wb_data,
    output logic [FLAG_W-1:0] wb_fflags,
    output logic [REG_W-1:0]  wb_dst,
    output logic              buf_gnt,
    output logic              ex2_done
);

    logic [DATA_W-1:0] buf_data;
    logic [FLAG_W-1:0] buf_fflags;
    logic [REG_W-1:0]  buf_dst;

    // Hold registers for the FDSU op: dst at issue, result at completion.
    // They only change on their load strobes, so a presented result is stable.
    always_ff @(posedge clk) begin
        if (dst_load) begin
            buf_dst <= dst_in;
        end
        if (res_load) begin
            buf_data   <= res_data;
            buf_fflags <= res_fflags;
        end
    end

    // Fixed-priority select; an EX2 op without a register write retires at
    // once without raising a request.
    always_comb begin
        wb_vld    = 1'b0;
        wb_data   = '0;
        wb_fflags = '0;
        wb_dst    = '0;
        buf_gnt   = 1'b0;
        ex2_done  = 1'b0;
        if (buf_vld) begin
            wb_vld    = 1'b1;
            wb_data   = buf_data;
            wb_fflags = buf_fflags;
            wb_dst    = buf_dst;
            buf_gnt   = grant;
        end else if (ex2_vld) begin
            ex2_done = !ex2_wb || grant;
            if (ex2_wb) begin
                wb_vld    = 1'b1;
                wb_data   = ex2_data;
                wb_fflags = ex2_fflags;
                wb_dst    = ex2_dst;
            end
        end
    end

endmodule

// File: rtl/pa_fpu_wb_ctrl.sv
// pa_fpu_wb_ctrl: FPU write-back controller. Tracks the EX2 pipe slot and
// one outstanding iterative FDSU op, arbitrates both onto the single
// register-file write port and stalls EX1 when the pipedown cannot proceed.
// Optional feature macro PA_FPU_WB_FFLAGS_ACC_EN adds a sticky accumulator of
// the fflags of every granted write-back, with a clear input from CP0.
module pa_fpu_wb_ctrl
    import pa_fpu_pkg::*;
#(
    parameter int FUNC_WIDTH = 10
) (
    input  logic              forever_cpuclk,
    input  logic              cpurst,
    input  logic              ctrl_xx_ex1_inst_vld,
    input  logic [SEL_W-1:0]  idu_fpu_ex1_eu_sel,
    input  logic              fdsu_fpu_ex1_special,
    input  logic [REG_W-1:0]  idu_fpu_ex1_dst,
    input  logic [DATA_W-1:0] dp_frbus_ex2_data,
    input  logic [FLAG_W-1:0] dp_frbus_ex2_fflags,
    input  logic              ex2_inst_wb,
    input  logic              fdsu_fpu_done,
    input  logic [DATA_W-1:0] fdsu_fpu_data,
    input  logic [FLAG_W-1:0] fdsu_fpu_fflags,
    input  logic              rtu_yy_xx_flush,
    output logic              ctrl_xx_ex1_stall,
    output logic              fpu_fdsu_kill,
`ifdef PA_FPU_WB_FFLAGS_ACC_EN
    input  logic              cp0_fpu_fflags_clr,
    output logic [FLAG_W-1:0] fpu_cp0_fflags_acc,
`endif
    pa_fpu_wb_ctrl_if.master  wb
);

    // Width of the EX1 function code this controller sits beside.
    typedef logic [FUNC_WIDTH-1:0] ex1_func_t;

    fdsu_state_e      state;
    logic             ex2_vld;
    logic [REG_W-1:0] ex2_dst;
    logic             fdsu_issue;
    logic             issue_go;
    logic             ex2_load;
    logic             res_load;
    logic             ex2_done;
    logic             buf_gnt;
    logic             stall;

    assign fdsu_issue = is_fdsu_issue(ctrl_xx_ex1_inst_vld, idu_fpu_ex1_eu_sel,
                                      fdsu_fpu_ex1_special);

    // EX1 must wait while EX2 is occupied and not leaving this cycle, or while
    // a new FDSU op meets an FDSU that is still busy or holding a result.
    assign stall = ctrl_xx_ex1_inst_vld &&
                   ((ex2_vld && !ex2_done) || (fdsu_issue && (state != ST_IDLE)));
    assign ctrl_xx_ex1_stall = stall;

    // Flush kills anything trying to enter EX2 or the FDSU this cycle.
    // issue_go implies IDLE, since any other state stalls an FDSU issue.
    assign issue_go = fdsu_issue && !stall && !rtu_yy_xx_flush;
    assign ex2_load = ctrl_xx_ex1_inst_vld && !stall && !fdsu_issue && !rtu_yy_xx_flush;
    assign res_load = (state == ST_RUN) && fdsu_fpu_done && !rtu_yy_xx_flush;

    // EX2 slot: new entries take priority over retirement so back-to-back ops
    // flow without a bubble; flush empties the slot.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            ex2_vld <= 1'b0;
        end else if (rtu_yy_xx_flush) begin
            ex2_vld <= 1'b0;
        end else if (ex2_load) begin
            ex2_vld <= 1'b1;
        end else if (ex2_done) begin
            ex2_vld <= 1'b0;
        end
    end

    // EX2 destination follows the pipedown; meaningful only while ex2_vld.
    always_ff @(posedge forever_cpuclk) begin
        if (ex2_load) begin
            ex2_dst <= idu_fpu_ex1_dst;
        end
    end

    // FDSU tracking FSM with registered kill; flush overrides done and grant,
    // and reset drops the op silently.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state         <= ST_IDLE;
            fpu_fdsu_kill <= 1'b0;
        end else begin
            fpu_fdsu_kill <= rtu_yy_xx_flush && (state == ST_RUN);
            if (rtu_yy_xx_flush) begin
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (issue_go)      state <= ST_RUN;
                    ST_RUN:  if (fdsu_fpu_done) state <= ST_WB;
                    ST_WB:   if (buf_gnt)       state <= ST_IDLE;
                    default:                    state <= ST_IDLE;
                endcase
            end
        end
    end

    pa_fpu_wb_arb u_arb (
        .clk        (forever_cpuclk),
        .dst_load   (issue_go),
        .dst_in     (idu_fpu_ex1_dst),
        .res_load   (res_load),
        .res_data   (fdsu_fpu_data),
        .res_fflags (fdsu_fpu_fflags),
        .buf_vld    (state == ST_WB),
        .ex2_vld    (ex2_vld),
        .ex2_wb     (ex2_inst_wb),
        .ex2_data   (dp_frbus_ex2_data),
        .ex2_fflags (dp_frbus_ex2_fflags),
        .ex2_dst    (ex2_dst),
        .grant      (wb.rf_fpu_wb_grant),
        .wb_vld     (wb.fpu_rf_wb_vld),
        .wb_data    (wb.fpu_rf_wb_data),
        .wb_fflags  (wb.fpu_rf_wb_fflags),
        .wb_dst     (wb.fpu_rf_wb_dst),
        .buf_gnt    (buf_gnt),
        .ex2_done   (ex2_done)
    );

`ifdef PA_FPU_WB_FFLAGS_ACC_EN
    // Sticky fflags of every accepted write; a clear beats a same-cycle write.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            fpu_cp0_fflags_acc <= '0;
        end else if (cp0_fpu_fflags_clr) begin
            fpu_cp0_fflags_acc <= '0;
        end else if (wb.fpu_rf_wb_vld && wb.rf_fpu_wb_grant) begin
            fpu_cp0_fflags_acc <= fpu_cp0_fflags_acc | wb.fpu_rf_wb_fflags;
        end
    end
`endif

endmodule
